uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter; together they form the UART peripheral behind the APB bridge. Samples an asynchronous 8N1 line (1 start, 8 data LSB-first, 1 stop, no parity) at a fixed clocks-per-bit rate. Presents each good byte on `data_byte` with a one-cycle `RX_done` strobe. Flags framing errors with a one-cycle `frame_error` strobe.

## Interface
- `CLKS_PER_BIT`, 2604, system clocks per bit; legal range 4..65535; `HALF` = (`CLKS_PER_BIT`-1)/2, integer division
- `clk`  input  1  system clock, all logic on rising edge
- `RST`  input  1  reset; one clock; reset is synchronous and active-high
- `enable`  input  1  receiver enable; low forces IDLE
- `RX`  input  1  asynchronous serial line, idle high
- `data_byte`  output  8  last correctly framed byte
- `RX_done`  output  1  one-cycle strobe, new byte on `data_byte`
- `RX_busy`  output  1  high while a frame is in progress
- `frame_error`  output  1  one-cycle strobe, stop bit sampled low

## Operation
- `RX` passes through a 2-flop synchronizer (`rx_s`); no other logic touches raw `RX`.
- Reset, at the clock edge with `RST`=1, overrides everything:
  - state IDLE, counters 0
  - synchronizer flops set to 1
  - `data_byte`=0x00, `RX_done`=0, `RX_busy`=0, `frame_error`=0
- States:
  - IDLE: if `enable` and `rx_s`=0, go to START with cnt=0.
  - START: count to `HALF`. At the edge where cnt==`HALF`, check the line. Low: go to DATA, cnt=0, bit index 0. High: glitch, back to IDLE with no strobe.
  - DATA: at each edge where cnt==`CLKS_PER_BIT`-1, sample into shift register bit[index] (LSB first) and clear cnt. After index 7, go to STOP.
  - STOP: at cnt==`CLKS_PER_BIT`-1, sample the line.
    - Sample 1: load `data_byte` from the shift register, pulse `RX_done`, go to IDLE.
    - Sample 0: pulse `frame_error`, leave `data_byte` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a false start during a held-low line.
- `RX_busy`=1 in START, DATA and STOP; 0 in IDLE and BREAK.
- `enable` low in any state: next state IDLE, no strobe, `data_byte` held. Re-enabling mid-frame resyncs on the next falling level seen in IDLE.
- `RX_done` and `frame_error` are never high together. Each is high for exactly one cycle.

## Timing
- Edge E0 is the first clock edge at which the synchronizer's first flop captures `RX`=0.
- START is entered at E2.
- Start-bit check is at E(3+`HALF`).
- Data bit k is sampled at E(3+`HALF`+(k+1)·`CLKS_PER_BIT`), k=0..7.
- Stop sample is at E(3+`HALF`+9·`CLKS_PER_BIT`).
- `RX_done`/`frame_error` and the new `data_byte` are registered at the stop-sample edge and visible in the following cycle. Total latency is fixed and exact; no tolerance.
- Back-to-back frames: the next start bit may begin one bit time after the stop bit begins. IDLE is reached before the next start edge reaches `rx_s`.
- Counter width: ceil(log2(`CLKS_PER_BIT`)) bits. The counter never wraps; it is cleared at each decision edge.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every decision edge uses a 2-of-3 majority of `rx_s` sampled at that edge and the two preceding edges. This applies to the start check, the data bits and the stop bit. Decision edges are unchanged. Single-cycle glitches on the line are rejected.
- Not defined: a single sample of `rx_s` at the decision edge. No vote logic is synthesized.
- Latency, ports and strobes are identical in both builds.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, so `HALF`=7 and the stop sample is at E154.
- Reset: `RST`=1 for 2 cycles with `RX`=1 -> all outputs 0, `data_byte`=0x00.
- Good frame 0xA5 driven at 16 clocks/bit -> `RX_done`=1 for one cycle after E154, `data_byte`=0xA5, `RX_busy` high from E2 through E154, `frame_error`=0.
- Two back-to-back frames 0x00 then 0xFF with no idle gap -> two `RX_done` pulses exactly 160 cycles apart, bytes 0x00 then 0xFF.
- Frame 0x3C with stop bit low, then line held low 40 more bit times -> `frame_error` one cycle after E154, `data_byte` keeps its previous value, `RX_busy`=0, no further strobes until the line returns high.
- `RX` low for 3 cycles then high (glitch) -> return to IDLE at E10, no strobe. Separately, `enable` dropped at bit 4 of a frame -> IDLE next cycle, no `RX_done`.
- Majority build (`UART_RX_MAJORITY_EN`): frame 0x55 with a one-cycle inverted pulse on `RX` aligned to each sample edge -> `data_byte`=0x55, `RX_done` at the same edge as the non-majority build.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver, the counterpart of the team UART transmitter.
// Samples the synchronized line once per bit at the bit centre, at a fixed CLKS_PER_BIT rate.
// Good bytes appear on data_byte with a one-cycle RX_done strobe. A low stop bit raises a
// one-cycle frame_error strobe, and the receiver then waits for the line to return high.
// Optional build macro: UART_RX_MAJORITY_EN. When it is defined, every decision edge uses a
// 2-of-3 vote over the last three synchronized samples. Decision edges, latency and ports
// are the same in both builds.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       enable,
  input  logic       RX,
  output logic [7:0] data_byte,
  output logic       RX_done,
  output logic       RX_busy,
  output logic       frame_error
);

  // Middle of the start bit, measured from the cycle after START is entered.
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e state_q, state_d;

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_byte_q, data_byte_d;
  logic             rx_done_q, rx_done_d;
  logic             frame_error_q, frame_error_d;

  logic             rx_bit;
  logic             cnt_at_half;
  logic             cnt_at_last;
  logic             last_bit;

  // Feed the raw line into the two-flop synchronizer; nothing else looks at RX.
  always_comb begin
    rx_meta_d = RX;
    rx_s_d    = rx_meta_q;
  end

  // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_h1_q, rx_h1_d;
  logic rx_h2_q, rx_h2_d;

  // Keep the two previous synchronized samples for the vote.
  always_comb begin
    rx_h1_d = rx_s_q;
    rx_h2_d = rx_h1_q;
  end

  // History flops start at the idle level, like the synchronizer.
  always_ff @(posedge clk) begin
    if (RST) begin
      rx_h1_q <= 1'b1;
      rx_h2_q <= 1'b1;
    end else begin
      rx_h1_q <= rx_h1_d;
      rx_h2_q <= rx_h2_d;
    end
  end

  // 2-of-3 vote over this edge and the two before it; a one-cycle glitch is out-voted.
  always_comb begin
    rx_bit = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
  end
`else
  // The value used at a decision edge is the synchronized line at that edge.
  always_comb begin
    rx_bit = rx_s_q;
  end
`endif

  // Counter and bit-index comparisons shared by the next-state and datapath logic.
  always_comb begin
    cnt_at_half = (cnt_q == CNT_HALF);
    cnt_at_last = (cnt_q == CNT_LAST);
    last_bit    = (bit_idx_q == 3'd7);
  end

  // All state-holding registers; reset puts the receiver in IDLE with cleared outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_byte_q   <= '0;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_byte_q   <= data_byte_d;
      rx_done_q     <= rx_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state logic. Disabling the receiver drops it back to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) state_d = S_START;
        end
        S_START: begin
          if (cnt_at_half) state_d = rx_bit ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (cnt_at_last && last_bit) state_d = S_STOP;
        end
        S_STOP: begin
          if (cnt_at_last) state_d = rx_bit ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: bit-time counter, LSB-first shift register, output byte and completion strobes.
  always_comb begin
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_byte_d   = data_byte_q;
    rx_done_d     = 1'b0;
    frame_error_d = 1'b0;
    if (!enable) begin
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end
        S_START: begin
          if (cnt_at_half) begin
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_at_last) begin
            cnt_d              = '0;
            shift_d[bit_idx_q] = rx_bit;
            if (!last_bit) bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_at_last) begin
            cnt_d = '0;
            if (rx_bit) begin
              data_byte_d = shift_q;
              rx_done_d   = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_BREAK: begin
          cnt_d = '0;
        end
        default: begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      endcase
    end
  end

  // Output decode: busy while a frame is being timed, not while idle or waiting out a break.
  always_comb begin
    RX_busy = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  end

  assign data_byte   = data_byte_q;
  assign RX_done     = rx_done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed checks of uart_receiver at 16 clocks per bit.
// Each scenario fills a per-cycle line/enable pattern, plays it one cycle at a time and
// records the outputs just after every edge; the recorded traces are then compared against
// hand-computed edge numbers (E0 = first edge after the line is driven low).
module tb_uart_receiver;

  localparam int unsigned CPB = 16;
  localparam int MAXLEN = 1024;

  logic       clk;
  logic       RST;
  logic       enable;
  logic       RX;
  logic [7:0] data_byte;
  logic       RX_done;
  logic       RX_busy;
  logic       frame_error;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .RST        (RST),
    .enable     (enable),
    .RX         (RX),
    .data_byte  (data_byte),
    .RX_done    (RX_done),
    .RX_busy    (RX_busy),
    .frame_error(frame_error)
  );

  // 10-time-unit system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rxPat   [0:MAXLEN-1];
  logic       enPat   [0:MAXLEN-1];
  logic       doneTr  [0:MAXLEN-1];
  logic       errTr   [0:MAXLEN-1];
  logic       busyTr  [0:MAXLEN-1];
  logic [7:0] dataTr  [0:MAXLEN-1];

  int passCount;
  int checkCount;
  int doneCount;
  int errCount;
  int bothCount;
  int firstDone;
  int lastDone;
  int firstErr;
  int busyLate;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Write one 8N1 frame into the pattern tables; cycles past the stop bit get tailVal.
  task automatic buildFrame(input int offset, input logic [7:0] b, input logic stopv,
                            input logic tailVal, input int len);
    for (int i = 0; i < len; i++) begin
      int  bitN;
      logic v;
      bitN = i / CPB;
      if (bitN == 0)      v = 1'b0;
      else if (bitN <= 8) v = b[bitN-1];
      else if (bitN == 9) v = stopv;
      else                v = tailVal;
      rxPat[offset+i] = v;
      enPat[offset+i] = 1'b1;
    end
  endtask

  // Play n cycles of the pattern; trace index i holds the outputs just after edge E(i).
  task automatic applyStimulus(input int n);
    doneCount = 0;
    errCount  = 0;
    bothCount = 0;
    firstDone = -1;
    lastDone  = -1;
    firstErr  = -1;
    for (int i = 0; i < n; i++) begin
      RST    = 1'b0;
      RX     = rxPat[i];
      enable = enPat[i];
      @(posedge clk);
      #1;
      doneTr[i] = RX_done;
      errTr[i]  = frame_error;
      busyTr[i] = RX_busy;
      dataTr[i] = data_byte;
      if (RX_done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) firstDone = i;
        lastDone = i;
      end
      if (frame_error === 1'b1) begin
        errCount++;
        if (firstErr < 0) firstErr = i;
      end
      if (RX_done === 1'b1 && frame_error === 1'b1) bothCount++;
    end
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;

    // Reset for two cycles with an idle line
    RST    = 1'b1;
    RX     = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data",  {24'd0, data_byte}, 32'h00);
    checkOutput("reset_done",  {31'd0, RX_done}, 32'd0);
    checkOutput("reset_busy",  {31'd0, RX_busy}, 32'd0);
    checkOutput("reset_ferr",  {31'd0, frame_error}, 32'd0);

    // Good frame 0xA5: stop sample at E154, strobe visible right after it
    $display("[TB] good frame 0xA5");
    buildFrame(0, 8'hA5, 1'b1, 1'b1, 170);
    applyStimulus(170);
    checkOutput("a5_done_count", doneCount, 1);
    checkOutput("a5_done_at",    firstDone, 154);
    checkOutput("a5_data",       {24'd0, dataTr[154]}, 32'hA5);
    checkOutput("a5_data_prev",  {24'd0, dataTr[153]}, 32'h00);
    checkOutput("a5_busy_e1",    {31'd0, busyTr[1]}, 32'd0);
    checkOutput("a5_busy_e2",    {31'd0, busyTr[2]}, 32'd1);
    checkOutput("a5_busy_e153",  {31'd0, busyTr[153]}, 32'd1);
    checkOutput("a5_busy_e154",  {31'd0, busyTr[154]}, 32'd0);
    checkOutput("a5_ferr_count", errCount, 0);

    // Back-to-back 0x00 then 0xFF with no idle gap
    $display("[TB] back-to-back 0x00, 0xFF");
    buildFrame(0,   8'h00, 1'b1, 1'b1, 160);
    buildFrame(160, 8'hFF, 1'b1, 1'b1, 160);
    applyStimulus(320);
    checkOutput("b2b_done_count", doneCount, 2);
    checkOutput("b2b_first_at",   firstDone, 154);
    checkOutput("b2b_second_at",  lastDone, 314);
    checkOutput("b2b_data0",      {24'd0, dataTr[154]}, 32'h00);
    checkOutput("b2b_data1",      {24'd0, dataTr[314]}, 32'hFF);
    checkOutput("b2b_ferr_count", errCount, 0);

    // Frame 0x3C with a low stop bit, line then held low for 40 more bit times
    $display("[TB] framing error 0x3C with held-low line");
    buildFrame(0, 8'h3C, 1'b0, 1'b0, 800);
    applyStimulus(800);
    busyLate = 0;
    for (int i = 155; i < 800; i++) if (busyTr[i] !== 1'b0) busyLate++;
    checkOutput("ferr_count",      errCount, 1);
    checkOutput("ferr_at",         firstErr, 154);
    checkOutput("ferr_done_count", doneCount, 0);
    checkOutput("ferr_data_held",  {24'd0, dataTr[799]}, 32'hFF);
    checkOutput("ferr_busy_late",  busyLate, 0);
    checkOutput("ferr_both",       bothCount, 0);

    // Line returns high: still no strobes
    for (int i = 0; i < 40; i++) begin
      rxPat[i] = 1'b1;
      enPat[i] = 1'b1;
    end
    applyStimulus(40);
    checkOutput("release_done", doneCount, 0);
    checkOutput("release_ferr", errCount, 0);
    checkOutput("release_busy", {31'd0, busyTr[39]}, 32'd0);

    // Three-cycle glitch: START at E2, start check finds the line high at E10
    $display("[TB] start-bit glitch");
    for (int i = 0; i < 40; i++) begin
      rxPat[i] = (i < 3) ? 1'b0 : 1'b1;
      enPat[i] = 1'b1;
    end
    applyStimulus(40);
    checkOutput("glitch_busy_e2",  {31'd0, busyTr[2]}, 32'd1);
    checkOutput("glitch_busy_e9",  {31'd0, busyTr[9]}, 32'd1);
    checkOutput("glitch_busy_e10", {31'd0, busyTr[10]}, 32'd0);
    checkOutput("glitch_done",     doneCount, 0);
    checkOutput("glitch_ferr",     errCount, 0);

    // Enable dropped during bit 4 of frame 0x96 and kept low for the rest of the frame
    $display("[TB] enable dropped mid-frame");
    buildFrame(0, 8'h96, 1'b1, 1'b1, 200);
    for (int i = 82; i < 200; i++) enPat[i] = 1'b0;
    applyStimulus(200);
    checkOutput("en_busy_e81", {31'd0, busyTr[81]}, 32'd1);
    checkOutput("en_busy_e82", {31'd0, busyTr[82]}, 32'd0);
    checkOutput("en_done",     doneCount, 0);
    checkOutput("en_ferr",     errCount, 0);
    checkOutput("en_data",     {24'd0, dataTr[199]}, 32'hFF);

    // Receiver recovers for a clean frame 0x69
    $display("[TB] recovery frame 0x69");
    buildFrame(0, 8'h69, 1'b1, 1'b1, 170);
    applyStimulus(170);
    checkOutput("rec_done_count", doneCount, 1);
    checkOutput("rec_done_at",    firstDone, 154);
    checkOutput("rec_data",       {24'd0, dataTr[154]}, 32'h69);

`ifdef UART_RX_MAJORITY_EN
    // Frame 0x55 with a one-cycle inverted pulse landing on each decision edge's newest sample
    $display("[TB] majority vote frame 0x55");
    buildFrame(0, 8'h55, 1'b1, 1'b1, 170);
    for (int k = 0; k < 10; k++) rxPat[8 + k*16] = ~rxPat[8 + k*16];
    applyStimulus(170);
    checkOutput("maj_done_count", doneCount, 1);
    checkOutput("maj_done_at",    firstDone, 154);
    checkOutput("maj_data",       {24'd0, dataTr[154]}, 32'h55);
    checkOutput("maj_ferr",       errCount, 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
